// File: rtl/priority_code_decoder.sv
// priority_code_decoder: turns buffered encoder codes into timed one-hot pulses
// on Y, with a pulse/gap pacing FSM and sticky per-line fired status.
module priority_code_decoder #(
    parameter int unsigned PULSE_LEN = 3,
    parameter int unsigned GAP_LEN   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] A,
    input  logic       v,
    output logic [7:0] Y,
    output logic       y_valid,
    output logic       busy,
    output logic [7:0] sticky,
    input  logic       sticky_clr
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        GAP
    } state_t;

    localparam logic [7:0] P_INIT = 8'(PULSE_LEN - 1);
    localparam logic [7:0] G_INIT = (GAP_LEN == 0) ? 8'd0 : 8'(GAP_LEN - 1);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [7:0] y_n;
    logic       yv_n;
    logic [7:0] sticky_n;

    logic [2:0] mem [2];
    logic       wr_ptr, rd_ptr;
    logic [1:0] count;
    logic       push, pop;
    logic [2:0] head;
    logic [7:0] head_oh;

    // Ready depends only on the registered count, so a same-cycle pop never frees a slot.
    assign in_ready = (count != 2'd2);
    assign push     = in_valid && in_ready && v;
    assign head     = mem[rd_ptr];
    assign head_oh  = 8'd1 << head;
    assign busy     = (state != IDLE) || (count != 2'd0);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        y_n     = Y;
        yv_n    = y_valid;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                y_n  = 8'd0;
                yv_n = 1'b0;
                if (count != 2'd0) begin
                    pop     = 1'b1;
                    y_n     = head_oh;
                    yv_n    = 1'b1;
                    cnt_n   = P_INIT;
                    state_n = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt != 8'd0) begin
                    cnt_n = cnt - 8'd1;
                end else begin
                    y_n  = 8'd0;
                    yv_n = 1'b0;
                    if (GAP_LEN == 0) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n   = G_INIT;
                        state_n = GAP;
                    end
                end
            end
            GAP: begin
                if (cnt != 8'd0) cnt_n = cnt - 8'd1;
                else state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // A pop coinciding with a clear leaves only the popped line set.
    assign sticky_n = (sticky_clr ? 8'd0 : sticky) | (pop ? head_oh : 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            Y       <= 8'd0;
            y_valid <= 1'b0;
            sticky  <= 8'd0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            Y       <= y_n;
            y_valid <= yv_n;
            sticky  <= sticky_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) rd_ptr <= ~rd_ptr;
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= A;
    end

endmodule

// File: doc/priority_code_decoder.md
Name: priority_code_decoder

Overview:
- Consumes the 3-bit code A and valid flag v produced by the 8:3 priority encoder and drives the matching 8-bit one-hot line as a timed pulse.
- Input side: valid/ready handshake with a 2-entry buffer. Output side: a pulse/gap state machine plus sticky per-line status.
- Sits between the request-encoding stage and downstream per-line event consumers.

Parameters:
- PULSE_LEN, 3, cycles each one-hot pulse is held on Y. Legal range 1..255.
- GAP_LEN, 2, minimum forced-zero cycles after each pulse. Legal range 0..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  code offered this cycle
- in_ready  output  1  block can accept a code this cycle
- A  input  3  encoded line index
- v  input  1  encoder valid flag; 0 = no line requested
- Y  output  8  one-hot decoded line, pulsed
- y_valid  output  1  high while Y carries a pulse
- busy  output  1  FSM not IDLE or buffer non-empty
- sticky  output  8  per-line "has fired" status
- sticky_clr  input  1  clears sticky

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (async) forces the following immediately, regardless of clk:
  - Y=0, y_valid=0, sticky=0, busy=0, in_ready=1
  - buffer emptied, FSM=IDLE, counter=0
- Handshake:
  - A transfer occurs on a rising edge with in_valid&&in_ready.
  - in_ready = (buffer count < 2), computed from registered count only. A pop in the same cycle does not free a slot for that cycle.
  - A transfer with v=1 writes A into the buffer.
  - A transfer with v=0 is consumed and discarded: no buffer write, no pulse, sticky unchanged.
  - A, v and in_valid are don't-care when no transfer occurs.
- Buffer: 2-entry FIFO, in-order. A push and a pop in the same edge are both performed.
- FSM states: IDLE, DRIVE, GAP; down-counter cnt, 8 bits.
  - IDLE, buffer non-empty: pop head h, Y<=1<<h, y_valid<=1, cnt<=PULSE_LEN-1, go to DRIVE.
  - IDLE, buffer empty: hold with Y=0.
  - DRIVE, cnt!=0: cnt<=cnt-1, Y held.
  - DRIVE, cnt==0:
    - Y<=0, y_valid<=0.
    - If GAP_LEN==0, go to IDLE.
    - Else cnt<=GAP_LEN-1, go to GAP.
  - GAP, cnt!=0: cnt<=cnt-1.
  - GAP, cnt==0: go to IDLE.
- Timing:
  - Latency: code accepted at edge N into an empty buffer with FSM IDLE → Y valid after edge N+1.
  - Pulse width is exactly PULSE_LEN cycles.
  - Back-to-back queued codes are separated by exactly GAP_LEN+1 zero cycles (GAP plus one IDLE pop cycle).
- Y is always all-zero or exactly one-hot; never multi-hot.
- sticky:
  - On each pop, sticky[h]<=1.
  - sticky_clr=1 clears all bits at the edge.
  - If a pop coincides with sticky_clr, the popped line's bit ends at 1 (set wins) and all other bits end at 0.
- busy = (state!=IDLE) || (count!=0); combinational from registers.
- No overflow is possible, because in_ready gates all writes. An in_valid held while in_ready=0 simply waits.
- Reset during DRIVE or GAP: pulse is truncated immediately; buffered codes are lost. After release, the block is idle with no residual pulse.

Test Plan (defaults PULSE_LEN=3, GAP_LEN=2):
- Reset, then idle 10 cycles → Y=0x00, y_valid=0, in_ready=1, busy=0, sticky=0x00 throughout.
- Single transfer A=5, v=1 at edge 0 → Y=0x20 and y_valid=1 after edges 1,2,3; Y=0x00 after edge 4; sticky=0x20; busy low after edge 6.
- Transfers A=0, 7, 3 on consecutive edges 0–2 (in_valid held) → in_ready=0 after edge 2. Y sequence: 0x01×3, 0x00×3, 0x80×3, 0x00×3, 0x08×3. Final sticky=0x89.
- Transfer A=6, v=0 → accepted (in_ready stays 1); Y stays 0x00, busy stays 0, sticky unchanged.
- sticky=0x01, then sticky_clr=1 on the same edge that pops A=2 → sticky=0x04 afterwards.
- rst asserted mid-DRIVE of A=4, with A=1 buffered → Y=0x00 immediately, without a clk edge. After release, no pulse ever appears; sticky=0x00, busy=0.
